bus_matrix_wb_port_arbiter: RTL and testbench

Per-slave-port tenure controller for the Wishbone crossbar. Shares one slave port between N_REQ masters using round-robin order. A grant is held for the whole WB cycle (CYC), so locked or multi-beat transfers are never split. A per-tenure watchdog terminates hung transfers with an error pulse to the owning master and an abort strobe toward the slave mux.

---
 rtl/bus_matrix_wb_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_bus_matrix_wb_port_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/bus_matrix_wb_port_arbiter.sv
// Round-robin tenure arbiter for one Wishbone slave port. The grant is held for the whole CYC and guarded by a watchdog.
// Optional per-tenure beat limit: define BUS_MATRIX_WB_ARB_BEAT_LIMIT_EN.
module bus_matrix_wb_port_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int MAX_BEATS      = 16,
  parameter int IDX_W          = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] cyc_i,
  input  logic             slv_ack_i,
  input  logic             slv_err_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             busy_o,
  output logic             abort_o,
  output logic [N_REQ-1:0] to_err_o,
  output logic [7:0]       to_count_o
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_OWN, ST_TERR} state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [7:0]       to_cnt_q, to_cnt_d;
  logic [N_REQ-1:0] own_oh;
  logic             win_vld;
  logic [IDX_W-1:0] win_idx;

`ifdef BUS_MATRIX_WB_ARB_BEAT_LIMIT_EN
  localparam int BEAT_W = $clog2(MAX_BEATS + 1);
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(MAX_BEATS);
  logic [BEAT_W-1:0] beat_q, beat_d, beat_nxt;
`endif

  assign own_oh = N_REQ'(1) << idx_q;

  // Scan from rr_q+1 upward; descending loop lets the nearest requester win.
  always_comb begin
    int unsigned cand;
    cand    = 0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = (int'(rr_q) + k) % N_REQ;
      if (req_i[cand]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    idx_d    = idx_q;
    rr_d     = rr_q;
    wd_d     = wd_q;
    to_cnt_d = to_cnt_q;
`ifdef BUS_MATRIX_WB_ARB_BEAT_LIMIT_EN
    beat_d   = beat_q;
    beat_nxt = (beat_q == BEAT_MAX) ? beat_q : beat_q + 1'b1;
`endif
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          state_d = ST_OWN;
          gnt_d   = N_REQ'(1) << win_idx;
          idx_d   = win_idx;
          rr_d    = win_idx;
          wd_d    = '0;
`ifdef BUS_MATRIX_WB_ARB_BEAT_LIMIT_EN
          beat_d  = '0;
`endif
        end
      end
      ST_OWN: begin
        if (!cyc_i[idx_q]) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end else if (slv_ack_i || slv_err_i) begin
          // A completing beat always beats the watchdog in the same cycle.
          wd_d = '0;
`ifdef BUS_MATRIX_WB_ARB_BEAT_LIMIT_EN
          beat_d = beat_nxt;
          if ((beat_nxt == BEAT_MAX) && |(req_i & ~own_oh)) begin
            state_d = ST_IDLE;
            gnt_d   = '0;
          end
`endif
        end else if (wd_q == WD_LAST) begin
          state_d  = ST_TERR;
          gnt_d    = '0;
          to_cnt_d = (to_cnt_q == 8'hFF) ? to_cnt_q : to_cnt_q + 8'd1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      ST_TERR: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      idx_q    <= '0;
      rr_q     <= IDX_W'(N_REQ - 1);
      wd_q     <= '0;
      to_cnt_q <= '0;
`ifdef BUS_MATRIX_WB_ARB_BEAT_LIMIT_EN
      beat_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      idx_q    <= idx_d;
      rr_q     <= rr_d;
      wd_q     <= wd_d;
      to_cnt_q <= to_cnt_d;
`ifdef BUS_MATRIX_WB_ARB_BEAT_LIMIT_EN
      beat_q   <= beat_d;
`endif
    end
  end

  assign gnt_o      = gnt_q;
  assign gnt_idx_o  = idx_q;
  assign busy_o     = (state_q == ST_OWN);
  assign abort_o    = (state_q == ST_TERR);
  assign to_err_o   = (state_q == ST_TERR) ? own_oh : '0;
  assign to_count_o = to_cnt_q;

endmodule

// File: tb/tb_bus_matrix_wb_port_arbiter.sv
// Directed bench for bus_matrix_wb_port_arbiter (N_REQ=4, TIMEOUT_CYCLES=8, MAX_BEATS=4).
module tb_bus_matrix_wb_port_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req_i = '0, cyc_i = '0;
  logic       slv_ack_i = 1'b0, slv_err_i = 1'b0;
  logic [3:0] gnt_o, to_err_o;
  logic [1:0] gnt_idx_o;
  logic       busy_o, abort_o;
  logic [7:0] to_count_o;

  int n_tests = 0;
  int n_fail  = 0;

  bus_matrix_wb_port_arbiter #(
    .N_REQ(4), .TIMEOUT_CYCLES(8), .MAX_BEATS(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .cyc_i(cyc_i),
    .slv_ack_i(slv_ack_i), .slv_err_i(slv_err_i), .gnt_o(gnt_o),
    .gnt_idx_o(gnt_idx_o), .busy_o(busy_o), .abort_o(abort_o),
    .to_err_o(to_err_o), .to_count_o(to_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req, cyc;
    logic       ack, err;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       busy, abort;
    logic [3:0] to_err;
    logic [7:0] to_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] req, input logic [3:0] cyc, input logic ack,
                     input logic err, input logic [3:0] gnt, input logic [1:0] idx,
                     input logic busy, input logic abort, input logic [3:0] to_err,
                     input logic [7:0] to_cnt);
    vec_t v;
    v.req = req; v.cyc = cyc; v.ack = ack; v.err = err; v.gnt = gnt; v.idx = idx;
    v.busy = busy; v.abort = abort; v.to_err = to_err; v.to_cnt = to_cnt;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [3:0] req, input logic [3:0] cyc, input logic ack);
    req_i = req; cyc_i = cyc; slv_ack_i = ack; slv_err_i = 1'b0;
  endtask

  initial begin
    logic [3:0] oh;
    int m;

    // Test 1: two requesters from reset (rr starts at 3, so master 0 wins first).
    add(4'b0101, 4'b0101, 0, 0, 4'b0001, 2'd0, 1, 0, 4'b0000, 8'd0);
    add(4'b0101, 4'b0101, 1, 0, 4'b0001, 2'd0, 1, 0, 4'b0000, 8'd0);
    add(4'b0100, 4'b0100, 0, 0, 4'b0000, 2'd0, 0, 0, 4'b0000, 8'd0);
    add(4'b0100, 4'b0100, 0, 0, 4'b0100, 2'd2, 1, 0, 4'b0000, 8'd0);
    add(4'b0000, 4'b0000, 0, 0, 4'b0000, 2'd2, 0, 0, 4'b0000, 8'd0);
    // Test 2: all four requesting, 3-beat tenures; rr is now 2 so order is 3,0,1,2,3.
    for (int t = 0; t < 4; t++) begin
      m  = (3 + t) % 4;
      oh = 4'b0001 << m;
      add(4'b1111, 4'b1111, 0, 0, oh, 2'(m), 1, 0, 4'b0000, 8'd0);
      for (int b = 0; b < 3; b++)
        add(4'b1111, 4'b1111, !(m == 2 && b == 1), (m == 2 && b == 1), oh, 2'(m), 1, 0, 4'b0000, 8'd0);
      add(4'b1111 & ~oh, 4'b1111 & ~oh, 0, 0, 4'b0000, 2'(m), 0, 0, 4'b0000, 8'd0);
    end
    add(4'b1111, 4'b1111, 0, 0, 4'b1000, 2'd3, 1, 0, 4'b0000, 8'd0);
    add(4'b0000, 4'b0000, 0, 0, 4'b0000, 2'd3, 0, 0, 4'b0000, 8'd0);
    // Test 3: master 1 hangs; TERR after 8 owned cycles, ACK during TERR ignored.
    add(4'b0010, 4'b0010, 0, 0, 4'b0010, 2'd1, 1, 0, 4'b0000, 8'd0);
    for (int i = 0; i < 7; i++)
      add(4'b0010, 4'b0010, 0, 0, 4'b0010, 2'd1, 1, 0, 4'b0000, 8'd0);
    add(4'b0010, 4'b0010, 0, 0, 4'b0000, 2'd1, 0, 1, 4'b0010, 8'd1);
    add(4'b0000, 4'b0000, 1, 0, 4'b0000, 2'd1, 0, 0, 4'b0000, 8'd1);
    // Test 4: ACK on the would-be timeout cycle restarts the watchdog.
    add(4'b0010, 4'b0010, 0, 0, 4'b0010, 2'd1, 1, 0, 4'b0000, 8'd1);
    for (int i = 0; i < 7; i++)
      add(4'b0010, 4'b0010, 0, 0, 4'b0010, 2'd1, 1, 0, 4'b0000, 8'd1);
    add(4'b0010, 4'b0010, 1, 0, 4'b0010, 2'd1, 1, 0, 4'b0000, 8'd1);
    for (int i = 0; i < 7; i++)
      add(4'b0010, 4'b0010, 0, 0, 4'b0010, 2'd1, 1, 0, 4'b0000, 8'd1);
    add(4'b0010, 4'b0010, 0, 0, 4'b0000, 2'd1, 0, 1, 4'b0010, 8'd2);
    add(4'b0000, 4'b0000, 0, 0, 4'b0000, 2'd1, 0, 0, 4'b0000, 8'd2);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", gnt_o, 4'b0000);
    chk("rst_idx", gnt_idx_o, 2'd0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_abort", abort_o, 1'b0);
    chk("rst_to_err", to_err_o, 4'b0000);
    chk("rst_to_count", to_count_o, 8'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      req_i = vecs[i].req; cyc_i = vecs[i].cyc;
      slv_ack_i = vecs[i].ack; slv_err_i = vecs[i].err;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_gnt", i), gnt_o, vecs[i].gnt);
      chk($sformatf("v%0d_idx", i), gnt_idx_o, vecs[i].idx);
      chk($sformatf("v%0d_busy", i), busy_o, vecs[i].busy);
      chk($sformatf("v%0d_abort", i), abort_o, vecs[i].abort);
      chk($sformatf("v%0d_to_err", i), to_err_o, vecs[i].to_err);
      chk($sformatf("v%0d_to_cnt", i), to_count_o, vecs[i].to_cnt);
      chk($sformatf("v%0d_onehot0", i), 32'($onehot0(gnt_o)), 32'd1);
    end

    // Timeout counter saturation: master 3 hangs repeatedly (10 cycles per event).
    drive(4'b1000, 4'b1000, 1'b0);
    repeat (2600) @(posedge clk);
    #1;
    chk("to_count_sat", to_count_o, 8'd255);
    drive(4'b0000, 4'b0000, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset mid-tenure
    drive(4'b0100, 4'b0100, 1'b0);
    @(posedge clk);
    #1;
    chk("pre_rst_gnt", gnt_o, 4'b0100);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_gnt", gnt_o, 4'b0000);
    chk("async_rst_busy", busy_o, 1'b0);
    chk("async_rst_to_count", to_count_o, 8'd0);
    #2 rst_n = 1'b1;
    drive(4'b1111, 4'b1111, 1'b0);
    @(posedge clk);
    #1;
    chk("post_rst_gnt", gnt_o, 4'b0001);
    chk("post_rst_idx", gnt_idx_o, 2'd0);

    // Beat limit: master 0 runs 10 beats while master 2 waits.
    drive(4'b0000, 4'b0000, 1'b0);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    drive(4'b0001, 4'b0001, 1'b0);
    @(posedge clk);
    #1;
    chk("bl_first_gnt", gnt_o, 4'b0001);
    for (int i = 1; i <= 10; i++) begin
      drive(4'b0101, 4'b0101, 1'b1);
      @(posedge clk);
      #1;
`ifdef BUS_MATRIX_WB_ARB_BEAT_LIMIT_EN
      if (i < 4) chk($sformatf("bl_beat%0d_gnt", i), gnt_o, 4'b0001);
      else if (i == 4) chk("bl_release_gnt", gnt_o, 4'b0000);
      else if (i == 5) chk("bl_next_gnt", gnt_o, 4'b0100);
`else
      chk($sformatf("bl_beat%0d_gnt", i), gnt_o, 4'b0001);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
